// File: rtl/piso_shift_feeder.sv
// Parallel-in/serial-out feeder: takes a WIDTH-bit word over valid/ready, streams it
// MSB-first with a shift strobe, then appends FLUSH zero bits to drain the downstream SISO.
module piso_shift_feeder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FLUSH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             shift,
    output logic             busy,
    output logic             done
);

    localparam int unsigned MAX_CNT    = (WIDTH > FLUSH) ? WIDTH : ((FLUSH > 1) ? FLUSH : 1);
    localparam int unsigned CNT_W      = $clog2(MAX_CNT) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'((FLUSH == 0) ? 0 : FLUSH - 1);
    localparam bit          HAS_FLUSH  = (FLUSH != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic               load_ready_q, load_ready_d;
    logic               serial_out_q, serial_out_d;
    logic               shift_q, shift_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   word_sh;
    logic               accept;

    // Outputs are precomputed for the cycle after each edge so every port is a flop.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        serial_out_d = 1'b0;
        shift_d      = 1'b0;
        done_d       = 1'b0;
        word_sh      = word_q << 1;
        accept       = load_valid && load_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    word_d       = data_in;
                    cnt_d        = '0;
                    serial_out_d = data_in[WIDTH-1];
                    shift_d      = 1'b1;
                    state_d      = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                word_d = word_sh;
                if (cnt_q == LAST_BIT) begin
                    cnt_d = '0;
                    if (HAS_FLUSH) begin
                        shift_d = 1'b1;
                        state_d = ST_FLUSH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d        = cnt_q + CNT_W'(1);
                    serial_out_d = word_sh[WIDTH-1];
                    shift_d      = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == LAST_FLUSH) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    shift_d = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        load_ready_d = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            word_q       <= '0;
            load_ready_q <= 1'b1;
            serial_out_q <= 1'b0;
            shift_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            load_ready_q <= load_ready_d;
            serial_out_q <= serial_out_d;
            shift_q      <= shift_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign serial_out = serial_out_q;
    assign shift      = shift_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_shift_feeder.sv
// Directed bench for piso_shift_feeder: per-cycle vector table on the 8/4 instance,
// plus hand sequences for WIDTH=1/FLUSH=0 and a WIDTH=4 instance feeding a SISO model.
module tb_piso_shift_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d8;
    logic       v8;
    logic       rdy8, ser8, sh8, bsy8, dn8;
    logic [0:0] d1;
    logic       v1;
    logic       rdy1, ser1, sh1, bsy1, dn1;
    logic [3:0] d4;
    logic       v4;
    logic       rdy4, ser4, sh4, bsy4, dn4;
    logic [3:0] ds_sr;
    logic       ds_out;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    piso_shift_feeder #(.WIDTH(8), .FLUSH(4)) u8 (
        .clock(clk), .reset(rst), .data_in(d8), .load_valid(v8), .load_ready(rdy8),
        .serial_out(ser8), .shift(sh8), .busy(bsy8), .done(dn8));

    piso_shift_feeder #(.WIDTH(1), .FLUSH(0)) u1 (
        .clock(clk), .reset(rst), .data_in(d1), .load_valid(v1), .load_ready(rdy1),
        .serial_out(ser1), .shift(sh1), .busy(bsy1), .done(dn1));

    piso_shift_feeder #(.WIDTH(4), .FLUSH(4)) u4 (
        .clock(clk), .reset(rst), .data_in(d4), .load_valid(v4), .load_ready(rdy4),
        .serial_out(ser4), .shift(sh4), .busy(bsy4), .done(dn4));

    // Downstream 4-bit SISO with its output register behind the last stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            ds_sr  <= '0;
            ds_out <= 1'b0;
        end else if (sh4) begin
            ds_sr  <= {ds_sr[2:0], ser4};
            ds_out <= ds_sr[3];
        end
    end

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic       ser;
        logic       sh;
        logic       bsy;
        logic       dn;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic v, input logic [7:0] d,
                                input logic s, input logic h, input logic b,
                                input logic n, input logic y);
        vec_t e;
        e.rst = r; e.valid = v; e.data = d;
        e.ser = s; e.sh = h; e.bsy = b; e.dn = n; e.rdy = y;
        tbl.push_back(e);
    endfunction

    // Accept w, then 7 more data bits, 4 flush bits and the done cycle (12 follow-on vectors).
    function automatic void add_stream(input logic [7:0] w, input logic [11:0] vmask,
                                       input logic [7:0] dd);
        add(1'b0, 1'b1, w, w[7], 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 6; i >= 0; i--)
            add(1'b0, vmask[6 - i], dd, w[i], 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            add(1'b0, vmask[7 + i], dd, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, vmask[11], dd, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    endfunction

    function automatic void add_idle();
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    initial begin
        // Reset with load_valid high must not capture anything.
        add(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_idle();
        add_stream(8'hA5, 12'h000, 8'h00);
        add_idle();
        // Back-to-back: valid held high, data changed to 0x01 while the 0xFF is in flight.
        add_stream(8'hFF, 12'hFFF, 8'h01);
        add_stream(8'h01, 12'h000, 8'h00);
        add_idle();
        // Stray valid pulse with 0x3C during the 0x81 stream.
        add_stream(8'h81, 12'h002, 8'h3C);
        add_idle();
        add_idle();
        // Reset in the 3rd shift cycle of 0xC3, then a clean 0x5A.
        add(1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_idle();
        add_stream(8'h5A, 12'h000, 8'h00);
        add_idle();

        v1 = 1'b0; d1 = 1'b0;
        v4 = 1'b0; d4 = 4'h0;

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            v8  = tbl[i].valid;
            d8  = tbl[i].data;
            step();
            n_vec++;
            if ({ser8, sh8, bsy8, dn8, rdy8} !==
                {tbl[i].ser, tbl[i].sh, tbl[i].bsy, tbl[i].dn, tbl[i].rdy}) begin
                n_err++;
                $display("FAIL vec%0d: got ser=%b sh=%b busy=%b done=%b rdy=%b, want ser=%b sh=%b busy=%b done=%b rdy=%b",
                         i, ser8, sh8, bsy8, dn8, rdy8,
                         tbl[i].ser, tbl[i].sh, tbl[i].bsy, tbl[i].dn, tbl[i].rdy);
            end
        end
        rst = 1'b0; v8 = 1'b0; d8 = 8'h00;

        // WIDTH=1, FLUSH=0: one data cycle, then done.
        check("w1_idle_rdy", 8'(rdy1), 8'h01);
        v1 = 1'b1; d1 = 1'b1;
        step();
        v1 = 1'b0; d1 = 1'b0;
        check("w1_bit", 8'({ser1, sh1, bsy1, rdy1}), 8'b1110);
        step();
        check("w1_done", 8'({ser1, sh1, bsy1, dn1, rdy1}), 8'b00011);
        step();
        check("w1_after", 8'({sh1, dn1, rdy1}), 8'b001);

        // WIDTH=4 into downstream SISO: 1,0,1,1 appears 5..8 edges after acceptance.
        v4 = 1'b1; d4 = 4'hB;
        step();
        v4 = 1'b0; d4 = 4'h0;
        check("e2e_first_bit", 8'({ser4, sh4}), 8'b11);
        for (int k = 1; k <= 4; k++) step();
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("e2e_ds_out%0d", k), 8'(ds_out), 8'(4'hB >> (3 - k) & 4'h1));
        end
        check("e2e_done", 8'({dn4, rdy4, sh4}), 8'b110);
        check("e2e_ds_drained", 8'(ds_sr), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/piso_shift_feeder.md
# piso_shift_feeder

Parallel-in/serial-out front end that drives the team's 4-bit SISO shift register. It accepts a WIDTH-bit word through a valid/ready handshake and emits it MSB-first on `serial_out`, with a `shift` strobe, one bit per clock. It then appends FLUSH zero bits, with `shift` held high, to drain the downstream register. `serial_out` connects to the downstream `serial_in`, and `shift` connects to the downstream `shift`.

## Interface
- WIDTH, 8, bits per word; legal range WIDTH >= 1.
- FLUSH, 4, number of trailing zero bits shifted after each word; legal range FLUSH >= 0. The default equals the downstream register depth.

Ports:
- clock  input  1  single clock; all logic is on the posedge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  parallel word; sampled only on acceptance.
- load_valid  input  1  word on data_in is valid.
- load_ready  output  1  block can accept a word; registered.
- serial_out  output  1  serial bit to the downstream serial_in; registered.
- shift  output  1  downstream shift enable; registered.
- busy  output  1  high in SHIFT and FLUSH.
- done  output  1  one-cycle pulse when a word plus its flush completes.

## Operation
- The FSM has three states: IDLE, SHIFT, FLUSH.
- **Word register and counter**
  - Word register: WIDTH bits.
  - Bit counter: width is clog2(max(WIDTH, FLUSH, 1)) + 1 bits, so it never wraps within a phase.
- **Acceptance**
  - A word is accepted on a clock edge where load_valid && load_ready && !reset.
  - On acceptance, data_in is copied into the word register.
- **IDLE**
  - load_ready=1, shift=0, serial_out=0, busy=0.
  - On acceptance, go to SHIFT.
- **SHIFT** (WIDTH cycles)
  - Each cycle: serial_out = current MSB, shift=1.
  - The word register shifts left with zero fill, and the counter increments.
  - After the WIDTH-th bit, go to FLUSH, or go directly to IDLE if FLUSH=0.
- **FLUSH** (FLUSH cycles)
  - serial_out=0, shift=1.
  - After the FLUSH-th cycle, go to IDLE.
- **done** asserts for exactly the first IDLE cycle after the final SHIFT or FLUSH cycle.
- **load_valid while busy**: ignored. load_ready is 0, nothing is captured, and the in-flight word is unaffected.
- **data_in changes after acceptance**: no effect on the word in flight.
- **Reset**
  - Reset values: state=IDLE, counter=0, word register=0.
  - Output reset values: load_ready=1, serial_out=0, shift=0, busy=0, done=0.
  - load_valid is ignored in any cycle where reset is high.
- **Reset mid-word or mid-flush**
  - Aborts the operation; outputs take their reset values at that edge.
  - No done pulse is produced, and the partial word is discarded.

## Timing
- Let L be the acceptance edge.
- **Data bits**: the cycles after edges L .. L+WIDTH-1 carry data bits MSB..LSB, with shift=1, busy=1, load_ready=0.
- **Flush bits**: the cycles after edges L+WIDTH .. L+WIDTH+FLUSH-1 carry zero bits with shift=1.
- **Completion**: after edge L+WIDTH+FLUSH the block is in IDLE with done=1 and load_ready=1.
- **Back-to-back words**
  - A word may be accepted at the done cycle's edge.
  - Minimum inter-word spacing is WIDTH+FLUSH+1 cycles, with exactly one shift=0 gap cycle between words.
- **Downstream latency**: the downstream SISO output register presents the last data bit 4 edges after that bit is captured. FLUSH=4 fully drains the downstream register.
- **Zero-latency reaction**: none. Every output is registered, and nothing is combinational from an input to an output.

## Test plan
- **Basic word**
  - Setup: WIDTH=8, FLUSH=4; data_in=0xA5 with load_valid accepted at edge L.
  - Required response: serial_out=1,0,1,0,0,1,0,1 then 0,0,0,0, with shift=1 for all 12 cycles.
  - Required response: done=1 only in the cycle after edge L+12, and busy=1 for exactly 12 cycles.
- **Back-to-back words**
  - Stimulus: 0xFF then 0x01, with load_valid held high.
  - Required response: the second word is accepted at the done edge, with one shift=0 gap cycle.
  - Required response: the second stream is 0,0,0,0,0,0,0,1,0,0,0,0.
- **Ignore while busy**
  - Stimulus: pulse load_valid with data_in=0x3C during SHIFT of 0x81.
  - Required response: the 0x81 stream is unchanged, no extra word is emitted, and load_ready stays 0 until the done cycle.
- **Reset mid-word**
  - Stimulus: assert reset in the 3rd SHIFT cycle of 0xC3.
  - Required response: at the next edge, serial_out=0, shift=0, busy=0, load_ready=1; no done pulse.
  - Required response: a following word 0x5A streams correctly.
- **FLUSH=0, WIDTH=1**
  - Stimulus: data_in=1.
  - Required response: exactly one cycle of serial_out=1 with shift=1, then done=1 in the next cycle.
- **End-to-end**
  - Setup: WIDTH=4, FLUSH=4, connected to the downstream SISO; input 0xB.
  - Required response: the downstream serial_out shows 1,0,1,1 on consecutive cycles starting 5 edges after the first bit is driven.
  - Required response: after the flush, the downstream register holds 0.
